// File: rtl/breakout_input_pkg.sv
// Shared repeat-FSM state type and default timing constants for the key conditioner.
package breakout_input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEF_DEBOUNCE_TIME = 10000;
  localparam int unsigned DEF_REPEAT_DELAY  = 5000000;
  localparam int unsigned DEF_REPEAT_RATE   = 1000000;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One key channel: 2-flop synchroniser, counter debounce, registered press/release pulses.
// The auto-repeat FSM exists only when BREAKOUT_KEY_REPEAT_EN is defined; otherwise repeat_o is 0.
module input_cond_ch
  import breakout_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TIME = DEF_DEBOUNCE_TIME,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE   = DEF_REPEAT_RATE
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pressed_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TIME);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TIME - 1);

  if (DEBOUNCE_TIME < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_cfg
    $error("input_cond_ch: timing parameters must be >= 2");
  end

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          s;

  assign s = sync_q[1];

  // The counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d  = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pressed_i};
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BREAKOUT_KEY_REPEAT_EN
  localparam int unsigned RW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_MAX = RW'(REPEAT_RATE - 1);

  rpt_state_e    rstate_q;
  logic [RW-1:0] rcnt_q;
  logic          rep_q;

  // Driven from the next-state debounce terms so the first repeat lands REPEAT_DELAY after the press pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rstate_q <= IDLE;
      rcnt_q   <= '0;
      rep_q    <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!stable_d) begin
        rstate_q <= IDLE;
        rcnt_q   <= '0;
      end else begin
        case (rstate_q)
          IDLE: begin
            if (press_d) begin
              rstate_q <= DELAY;
              rcnt_q   <= '0;
            end
          end
          DELAY: begin
            if (rcnt_q == RD_MAX) begin
              rep_q    <= 1'b1;
              rcnt_q   <= '0;
              rstate_q <= REPEAT;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (rcnt_q == RR_MAX) begin
              rep_q  <= 1'b1;
              rcnt_q <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            rstate_q <= IDLE;
            rcnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/breakout_input_cond.sv
// N-channel key conditioner: pin polarity and mask normalisation feeding one input_cond_ch per key.
// Optional auto-repeat is enabled by defining BREAKOUT_KEY_REPEAT_EN.
module breakout_input_cond
  import breakout_input_pkg::*;
#(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned DEBOUNCE_TIME = DEF_DEBOUNCE_TIME,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE   = DEF_REPEAT_RATE
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] key_in,
  input  logic [N_CH-1:0] key_mask,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  logic [N_CH-1:0] pressed;

  // A masked key looks released, so it drops through the normal debounce path.
  assign pressed = (ACTIVE_LOW ? ~key_in : key_in) & ~key_mask;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    input_cond_ch #(
      .DEBOUNCE_TIME (DEBOUNCE_TIME),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_n_i   (sys_rst_n),
      .pressed_i (pressed[g]),
      .level_o   (level_out[g]),
      .press_o   (press_pulse[g]),
      .release_o (release_pulse[g]),
      .repeat_o  (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_breakout_input_cond.sv
// Bench for breakout_input_cond: fixed vector table, hand-written corner sequences, random run vs history model.
module tb_breakout_input_cond;

  localparam int N_CH = 3;
  localparam int DT   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int HL   = 2 + DT;
`ifdef BREAKOUT_KEY_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [N_CH-1:0] key_in, key_mask;
  logic [N_CH-1:0] level_out, press_pulse, release_pulse, repeat_pulse;

  breakout_input_cond #(
    .N_CH(N_CH), .DEBOUNCE_TIME(DT), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in), .key_mask(key_mask),
    .level_out(level_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: history of normalised pin values, newest first.
  bit              hist [N_CH][HL];
  bit              m_lvl [N_CH];
  int              m_press_edge [N_CH];
  int              edge_no = 0;
  logic [N_CH-1:0] e_lvl, e_prs, e_rel, e_rpt;

  task automatic model_edge();
    bit all_diff;
    int d;
    edge_no++;
    e_prs = '0; e_rel = '0; e_rpt = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!sys_rst_n) begin
        for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
        m_lvl[c] = 1'b0;
      end else begin
        for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = ~key_in[c] & ~key_mask[c];
        // accept when the DT synchronised samples (2 edges old and older) all disagree
        all_diff = 1'b1;
        for (int j = 2; j < HL; j++) if (hist[c][j] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e_prs[c] = 1'b1;
            m_press_edge[c] = edge_no;
          end else begin
            e_rel[c] = 1'b1;
          end
        end else if (RPT && m_lvl[c]) begin
          d = edge_no - m_press_edge[c];
          if (d >= RD && (d - RD) % RR == 0) e_rpt[c] = 1'b1;
        end
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    checks++;
    if (level_out !== e_lvl || press_pulse !== e_prs || release_pulse !== e_rel || repeat_pulse !== e_rpt) begin
      errors++;
      $display("FAIL model edge=%0d got lvl=%b prs=%b rel=%b rpt=%b want lvl=%b prs=%b rel=%b rpt=%b",
               edge_no, level_out, press_pulse, release_pulse, repeat_pulse, e_lvl, e_prs, e_rel, e_rpt);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, edge_no, got, want);
    end
  endtask

  typedef struct packed {
    logic [2:0] key;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] key, input logic [2:0] lvl, input logic [2:0] prs,
                     input logic [2:0] rel, input int n);
    vec_t v;
    v.key = key; v.lvl = lvl; v.prs = prs; v.rel = rel;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic idle(input int n);
    key_in = 3'b111;
    key_mask = 3'b000;
    for (int i = 0; i < n; i++) step();
  endtask

  int unsigned pdiv;

  initial begin
    // clean press / release on ch0
    add(3'b110, 3'b000, 3'b000, 3'b000, 5);
    add(3'b110, 3'b001, 3'b001, 3'b000, 1);
    add(3'b110, 3'b001, 3'b000, 3'b000, 1);
    add(3'b111, 3'b001, 3'b000, 3'b000, 5);
    add(3'b111, 3'b000, 3'b000, 3'b001, 1);
    add(3'b111, 3'b000, 3'b000, 3'b000, 1);
    // 3-cycle glitch on ch1 is rejected
    add(3'b101, 3'b000, 3'b000, 3'b000, 3);
    add(3'b111, 3'b000, 3'b000, 3'b000, 6);
    // 4-cycle low on ch1 is accepted, then released
    add(3'b101, 3'b000, 3'b000, 3'b000, 4);
    add(3'b111, 3'b000, 3'b000, 3'b000, 1);
    add(3'b111, 3'b010, 3'b010, 3'b000, 1);
    add(3'b111, 3'b010, 3'b000, 3'b000, 3);
    add(3'b111, 3'b000, 3'b000, 3'b010, 1);
    add(3'b111, 3'b000, 3'b000, 3'b000, 1);

    sys_rst_n = 1'b0;
    key_in    = 3'b111;
    key_mask  = 3'b000;
    step();
    step();
    chk("reset_outputs", {level_out, press_pulse, release_pulse, repeat_pulse}, '0);
    sys_rst_n = 1'b1;
    idle(3);

    foreach (tbl[i]) begin
      key_in = tbl[i].key;
      step();
      chk($sformatf("tbl[%0d]", i), {level_out, press_pulse, release_pulse},
          {tbl[i].lvl, tbl[i].prs, tbl[i].rel});
    end

    // simultaneous press on ch0/ch2, then mask ch2 while held
    idle(4);
    key_in = 3'b010;
    for (int i = 0; i < 5; i++) step();
    chk("simul_before", level_out, 3'b000);
    step();
    chk("simul_press", {level_out, press_pulse}, {3'b101, 3'b101});
    key_mask = 3'b100;
    for (int i = 0; i < 5; i++) step();
    chk("mask_no_instant_drop", level_out, 3'b101);
    step();
    chk("mask_release", {level_out, release_pulse, press_pulse}, {3'b001, 3'b100, 3'b000});
    idle(12);

    // reset at debounce count 2, restart, then reset while pressed
    key_in = 3'b110;
    for (int i = 0; i < 4; i++) step();
    sys_rst_n = 1'b0;
    step();
    chk("rst_mid_debounce", {level_out, press_pulse, release_pulse, repeat_pulse}, '0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("rst_restart_wait", level_out, 3'b000);
    step();
    chk("rst_restart_press", {level_out, press_pulse}, {3'b001, 3'b001});
    step();
    step();
    sys_rst_n = 1'b0;
    step();
    chk("rst_while_held", {level_out, press_pulse, release_pulse, repeat_pulse}, '0);
    sys_rst_n = 1'b1;
    step();
    chk("rst_no_residual", {level_out, press_pulse, release_pulse, repeat_pulse}, '0);
    idle(12);

    // auto-repeat hold on ch0; release accepted on the cycle a repeat would otherwise fall
    key_in = 3'b110;
    for (int i = 0; i < 5; i++) step();
    step();
    chk("rpt_press", press_pulse, 3'b001);
    for (int d = 1; d <= 30; d++) begin
      if (d == 17) key_in = 3'b111;
      step();
      chk($sformatf("rpt_d%0d", d), repeat_pulse,
          {2'b00, RPT && (d == 10 || d == 13 || d == 16 || d == 19)});
      if (d == 22) chk("rpt_release", {level_out[0], release_pulse[0]}, 2'b01);
    end

    // random run against the history model
    key_in   = 3'b111;
    key_mask = 3'b000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      pdiv = ((cyc / 200) % 2 == 0) ? 4 : 40;
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(pdiv - 1) == 0) key_in[c] = ~key_in[c];
        if ($urandom_range(59) == 0) key_mask[c] = ~key_mask[c];
      end
      sys_rst_n = ($urandom_range(399) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
